// File: rtl/write_data_router_if.sv
// W-channel routing bundle: AW queue push side, master W channel, per-slave W channels and status.
// The router sits on the slave modport; the driving environment uses the master modport.
interface write_data_router_if #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int NUM_SLAVES = 2
);
  logic                           AW_Push;
  logic [NUM_SLAVES-1:0]          Q_Enables;
  logic [LEN_W-1:0]               AW_Len;
  logic                           Queue_Full;
  logic [DATA_W-1:0]              Master_AXI_wdata;
  logic [DATA_W/8-1:0]            Master_AXI_wstrb;
  logic                           Master_AXI_wlast;
  logic                           Master_AXI_wvalid;
  logic                           Master_AXI_wready;
  logic [NUM_SLAVES*DATA_W-1:0]   slave_wdata;
  logic [NUM_SLAVES*DATA_W/8-1:0] slave_wstrb;
  logic [NUM_SLAVES-1:0]          slave_wlast;
  logic [NUM_SLAVES-1:0]          slave_wvalid;
  logic [NUM_SLAVES-1:0]          slave_wready;
  logic                           Wlast_Err;
  logic                           Ovf_Err;

  modport slave (
    input  AW_Push, Q_Enables, AW_Len,
    input  Master_AXI_wdata, Master_AXI_wstrb, Master_AXI_wlast, Master_AXI_wvalid,
    input  slave_wready,
    output Queue_Full, Master_AXI_wready,
    output slave_wdata, slave_wstrb, slave_wlast, slave_wvalid,
    output Wlast_Err, Ovf_Err
  );

  modport master (
    output AW_Push, Q_Enables, AW_Len,
    output Master_AXI_wdata, Master_AXI_wstrb, Master_AXI_wlast, Master_AXI_wvalid,
    output slave_wready,
    input  Queue_Full, Master_AXI_wready,
    input  slave_wdata, slave_wstrb, slave_wlast, slave_wvalid,
    input  Wlast_Err, Ovf_Err
  );
endinterface

// File: rtl/write_data_router.sv
// Steers master W beats to the slave chosen by the oldest outstanding AW; burst ends are
// taken from an internal beat counter, the master's wlast is only cross-checked.
module write_data_router #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int NUM_SLAVES = 2,
  parameter int DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  write_data_router_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [SEL_W-1:0]  q_sel  [DEPTH];
  logic              q_sink [DEPTH];
  logic [LEN_W-1:0]  q_len  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count, count_nxt;
  logic [LEN_W-1:0]  beat_cnt;
  logic              full_q, wlast_err_q, ovf_err_q;

  logic [SEL_W-1:0]      push_sel, head_sel;
  logic                  head_sink;
  logic [LEN_W-1:0]      head_len;
  logic                  empty, head_last, beat, pop, push_ok;
  logic                  wready_c;
  logic [NUM_SLAVES-1:0] wvalid_c, wlast_c;

  // Lowest set bit wins on a multi-hot select; all-zero routes to the sink.
  always_comb begin
    push_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (bus.Q_Enables[i]) push_sel = SEL_W'(i);
    end
  end

  assign head_sel  = q_sel[rd_ptr];
  assign head_sink = q_sink[rd_ptr];
  assign head_len  = q_len[rd_ptr];
  assign empty     = (count == '0);
  assign head_last = (beat_cnt == head_len);

  always_comb begin
    wready_c = 1'b0;
    wvalid_c = '0;
    wlast_c  = '0;
    if (!empty) begin
      if (head_sink) begin
        wready_c = 1'b1;
      end else begin
        wvalid_c[head_sel] = bus.Master_AXI_wvalid;
        wlast_c[head_sel]  = head_last;
        wready_c           = bus.slave_wready[head_sel];
      end
    end
  end

  assign bus.Master_AXI_wready = wready_c;
  assign bus.slave_wvalid      = wvalid_c;
  assign bus.slave_wlast       = wlast_c;
  assign bus.slave_wdata       = {NUM_SLAVES{bus.Master_AXI_wdata}};
  assign bus.slave_wstrb       = {NUM_SLAVES{bus.Master_AXI_wstrb}};
  assign bus.Queue_Full        = full_q;
  assign bus.Wlast_Err         = wlast_err_q;
  assign bus.Ovf_Err           = ovf_err_q;

  assign beat = bus.Master_AXI_wvalid && wready_c && !empty;
  assign pop  = beat && head_last;
  // A push into a full queue is still taken when the head pops in the same cycle.
  assign push_ok = bus.AW_Push && (!full_q || pop);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + (PTR_W+1)'(1);
    else if (pop && !push_ok) count_nxt = count - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full_q      <= 1'b0;
      beat_cnt    <= '0;
      wlast_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      count  <= count_nxt;
      full_q <= (count_nxt == (PTR_W+1)'(DEPTH));
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (beat) begin
        beat_cnt <= head_last ? '0 : beat_cnt + LEN_W'(1);
        if (bus.Master_AXI_wlast != head_last) wlast_err_q <= 1'b1;
      end
      if (bus.AW_Push && !push_ok) ovf_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_sel[wr_ptr]  <= push_sel;
      q_sink[wr_ptr] <= ~|bus.Q_Enables;
      q_len[wr_ptr]  <= bus.AW_Len;
    end
  end
endmodule

// File: tb/tb_write_data_router.sv
// Bench for write_data_router: vector table, corner-case sequences and random traffic,
// all cross-checked against a queue-based model of the AW ordering rules.
module tb_write_data_router;
  localparam int DW = 32, LW = 8, NS = 2, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  write_data_router_if #(.DATA_W(DW), .LEN_W(LW), .NUM_SLAVES(NS)) bus ();
  write_data_router #(.DATA_W(DW), .LEN_W(LW), .NUM_SLAVES(NS), .DEPTH(DEPTH))
    dut (.clk(clk), .reset_n(rst_n), .bus(bus));

  typedef struct { int sel; bit sink; int len; } entry_t;
  entry_t mq[$];
  int     m_bc;
  bit     m_werr, m_ovf;

  int checks = 0, errors = 0;

  logic          c_push, c_wv, c_wl;
  logic [NS-1:0] c_en, c_srdy;
  logic [LW-1:0] c_len;
  logic [DW-1:0] c_wdata;
  logic [3:0]    c_wstrb;
  logic          e_rdy;
  logic [NS-1:0] e_vld, e_lst;

  typedef struct {
    logic p; logic [1:0] en; logic [7:0] len; logic wv, wl; logic [1:0] srdy;
    logic rdy; logic [1:0] vld, lst;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_bc = 0; m_werr = 0; m_ovf = 0;
  endfunction

  function automatic void model_expect();
    e_rdy = 1'b0; e_vld = '0; e_lst = '0;
    if (mq.size() != 0) begin
      if (mq[0].sink) e_rdy = 1'b1;
      else begin
        e_rdy             = c_srdy[mq[0].sel];
        e_vld[mq[0].sel]  = c_wv;
        e_lst[mq[0].sel]  = (m_bc == mq[0].len);
      end
    end
  endfunction

  function automatic void model_update();
    bit beat, full_pre, popped, is_last;
    entry_t e;
    beat = c_wv && e_rdy && (mq.size() != 0);
    full_pre = (mq.size() == DEPTH);
    popped = 0;
    if (beat) begin
      is_last = (m_bc == mq[0].len);
      if (c_wl != is_last) m_werr = 1;
      if (is_last) begin
        void'(mq.pop_front());
        m_bc = 0;
        popped = 1;
      end else m_bc++;
    end
    if (c_push) begin
      if (full_pre && !popped) m_ovf = 1;
      else begin
        e.sink = (c_en == 0);
        e.sel = 0;
        for (int i = NS - 1; i >= 0; i--) if (c_en[i]) e.sel = i;
        e.len = int'(c_len);
        mq.push_back(e);
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    model_expect();
    chk({tag, "_wready"}, 64'(bus.Master_AXI_wready), 64'(e_rdy));
    chk({tag, "_wvalid"}, 64'(bus.slave_wvalid), 64'(e_vld));
    chk({tag, "_wlast"},  64'(bus.slave_wlast), 64'(e_lst));
    chk({tag, "_full"},   64'(bus.Queue_Full), 64'(mq.size() == DEPTH));
    chk({tag, "_werr"},   64'(bus.Wlast_Err), 64'(m_werr));
    chk({tag, "_ovf"},    64'(bus.Ovf_Err), 64'(m_ovf));
    if (mq.size() != 0 && !mq[0].sink) begin
      chk({tag, "_wdata"}, 64'(bus.slave_wdata[mq[0].sel*DW +: DW]), 64'(c_wdata));
      chk({tag, "_wstrb"}, 64'(bus.slave_wstrb[mq[0].sel*4 +: 4]), 64'(c_wstrb));
    end
  endtask

  task automatic step(input logic p, input logic [NS-1:0] en, input logic [LW-1:0] len,
                      input logic wv, input logic wl, input logic [NS-1:0] srdy);
    @(negedge clk);
    c_push = p; c_en = en; c_len = len; c_wv = wv; c_wl = wl; c_srdy = srdy;
    c_wdata = $urandom; c_wstrb = 4'($urandom_range(0, 15));
    bus.AW_Push = p; bus.Q_Enables = en; bus.AW_Len = len;
    bus.Master_AXI_wvalid = wv; bus.Master_AXI_wlast = wl; bus.slave_wready = srdy;
    bus.Master_AXI_wdata = c_wdata; bus.Master_AXI_wstrb = c_wstrb;
    #1;
    check_outputs("cyc");
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
  endtask

  task automatic cyc(input logic p, input logic [NS-1:0] en, input logic [LW-1:0] len,
                     input logic wv, input logic wl, input logic [NS-1:0] srdy);
    step(p, en, len, wv, wl, srdy);
    advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lastcnt, lastbeat;
    logic exp_last, wl, p;

    rst_n = 1'b0;
    c_push = 0; c_en = '0; c_len = '0; c_wv = 0; c_wl = 0; c_srdy = '0;
    c_wdata = '0; c_wstrb = '0;
    bus.AW_Push = 0; bus.Q_Enables = '0; bus.AW_Len = '0;
    bus.Master_AXI_wvalid = 0; bus.Master_AXI_wlast = 0; bus.slave_wready = '0;
    bus.Master_AXI_wdata = '0; bus.Master_AXI_wstrb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Single burst to slave 1, then three interleaved bursts with a slave-1 stall.
    tbl.push_back('{1'b1, 2'b10, 8'd3, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 2'b10});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00});
    tbl.push_back('{1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00});
    tbl.push_back('{1'b1, 2'b10, 8'd1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 2'b01});
    tbl.push_back('{1'b1, 2'b01, 8'd2, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 2'b01});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b10, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b10, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b10, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 2'b10});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 2'b01});
    tbl.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].p, tbl[i].en, tbl[i].len, tbl[i].wv, tbl[i].wl, tbl[i].srdy);
      chk($sformatf("tbl%0d_wready", i), 64'(bus.Master_AXI_wready), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_wvalid", i), 64'(bus.slave_wvalid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_wlast", i),  64'(bus.slave_wlast), 64'(tbl[i].lst));
      advance();
    end
    chk("tbl_werr", 64'(bus.Wlast_Err), 64'(0));

    // Fill, overflow, then pop and push together while full.
    repeat (4) cyc(1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 2'b11);
    step(1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 2'b11);
    chk("full_after4", 64'(bus.Queue_Full), 64'(1));
    advance();
    step(1'b1, 2'b10, 8'd0, 1'b1, 1'b1, 2'b11);
    chk("ovf_set", 64'(bus.Ovf_Err), 64'(1));
    chk("full_pop_rdy", 64'(bus.Master_AXI_wready), 64'(1));
    advance();
    step(1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 2'b11);
    chk("full_kept", 64'(bus.Queue_Full), 64'(1));
    advance();
    repeat (4) cyc(1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11);
    step(1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 2'b11);
    chk("drained_full", 64'(bus.Queue_Full), 64'(0));
    advance();

    // Sink burst with a premature master wlast.
    do_reset();
    cyc(1'b1, 2'b00, 8'd1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b00);
    chk("sink_wready", 64'(bus.Master_AXI_wready), 64'(1));
    chk("sink_wvalid", 64'(bus.slave_wvalid), 64'(0));
    advance();
    step(1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b00);
    chk("werr_set", 64'(bus.Wlast_Err), 64'(1));
    advance();

    // 256-beat burst.
    cyc(1'b1, 2'b10, 8'd255, 1'b0, 1'b0, 2'b11);
    lastcnt = 0; lastbeat = -1;
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 2'b00, 8'd0, 1'b1, (i == 255), 2'b11);
      if (bus.slave_wlast[1]) begin lastcnt++; lastbeat = i; end
      advance();
    end
    chk("max_wlast_count", 64'(lastcnt), 64'(1));
    chk("max_wlast_beat", 64'(lastbeat), 64'(255));
    cyc(1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 2'b11);
    step(1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11);
    chk("after_max_wlast", 64'(bus.slave_wlast), 64'(2'b01));
    advance();

    // Reset in the middle of a 4-beat burst.
    cyc(1'b1, 2'b01, 8'd3, 1'b0, 1'b0, 2'b11);
    repeat (2) cyc(1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11);
    do_reset();
    chk("midrst_werr", 64'(bus.Wlast_Err), 64'(0));
    cyc(1'b1, 2'b10, 8'd1, 1'b0, 1'b0, 2'b11);
    step(1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11);
    chk("postrst_beat1", 64'(bus.slave_wlast), 64'(2'b00));
    advance();
    step(1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11);
    chk("postrst_beat2", 64'(bus.slave_wlast), 64'(2'b10));
    advance();

    // Random traffic.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      exp_last = (mq.size() != 0) && (m_bc == mq[0].len);
      wl = ($urandom_range(0, 19) == 0) ? !exp_last : exp_last;
      p = ($urandom_range(0, 2) == 0) && (mq.size() < DEPTH || $urandom_range(0, 9) == 0);
      cyc(p, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0), wl, 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_data_router.md
Name: write_data_router

Overview:
- Sits directly downstream of the write address decoder and routes the master W channel to the slave selected by each accepted AW transaction.
- Each AW handshake pushes the decoder's one-hot slave select (Q_Enables) and the burst length into an in-order queue.
- W beats are steered to the slave at the queue head; the head is popped on the burst's final beat.
- An internal beat counter, not the master's wlast, defines the end of each burst.

Parameters:
DATA_W, 32, W data width
LEN_W, 8, AWLEN width
NUM_SLAVES, 2, number of slave ports
DEPTH, 4, outstanding-AW queue depth (power of 2, >=2)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
AW_Push  input  1  AW handshake accepted by decoder this cycle
Q_Enables  input  NUM_SLAVES  one-hot slave select for the pushed AW
AW_Len  input  LEN_W  AWLEN of the pushed AW
Queue_Full  output  1  queue holds DEPTH entries; decoder must hold awready low
Master_AXI_wdata  input  DATA_W  master write data
Master_AXI_wstrb  input  DATA_W/8  master byte strobes
Master_AXI_wlast  input  1  master last flag (checked only)
Master_AXI_wvalid  input  1  master W valid
Master_AXI_wready  output  1  W ready to master
slave_wdata  output  NUM_SLAVES*DATA_W  per-slave data, slice i for slave i
slave_wstrb  output  NUM_SLAVES*DATA_W/8  per-slave strobes
slave_wlast  output  NUM_SLAVES  per-slave last, counter-generated
slave_wvalid  output  NUM_SLAVES  per-slave valid
slave_wready  input  NUM_SLAVES  per-slave ready
Wlast_Err  output  1  sticky: master wlast disagreed with beat count
Ovf_Err  output  1  sticky: AW_Push while full

Behaviour:
- Reset (asynchronous, any cycle):
  - Queue empties; beat counter = 0.
  - Queue_Full = 0, Wlast_Err = 0, Ovf_Err = 0.
  - All slave_wvalid = 0, Master_AXI_wready = 0.
  - Any in-flight burst is abandoned.
- Queue:
  - Circular FIFO with read/write pointers and a count.
  - Each entry = {sel index, sink flag, len}.
  - Sel index = lowest set bit of Q_Enables. Multi-hot selects lowest index.
  - All-zero Q_Enables sets the sink flag.
  - Queue_Full = (count == DEPTH), registered with the count.
- Push:
  - On AW_Push with !Queue_Full, write the entry.
  - AW_Push while full: entry dropped, Ovf_Err set.
- Routing is combinational from the head entry and the counter; there is no data storage.
  - Empty queue: Master_AXI_wready = 0, all slave_wvalid = 0.
  - Head selects slave i:
    - slave_wvalid[i] = Master_AXI_wvalid.
    - Master_AXI_wready = slave_wready[i].
    - slave_wdata and slave_wstrb slice i = master values.
    - slave_wlast[i] = (beat_cnt == len).
    - All other slaves: wvalid = 0, wlast = 0.
    - Data slices of unselected slaves also carry the master data; this is a don't-care.
  - Head is sink:
    - Master_AXI_wready = 1; beats are consumed and discarded.
    - No slave valid is asserted.
- Beat handshake = Master_AXI_wvalid && Master_AXI_wready with a non-empty queue.
  - Not last (beat_cnt != len): beat_cnt increments.
  - Last (beat_cnt == len): beat_cnt -> 0 and the head pops.
  - Next burst begins the following cycle, with no bubble beyond that cycle.
- Wlast check: on every beat handshake, Master_AXI_wlast != (beat_cnt == len) sets Wlast_Err. Routing is unaffected.
- Latency:
  - An entry pushed in cycle N is visible at the head in cycle N+1.
  - There is no push-to-head bypass; a W beat presented in cycle N to an empty queue waits.
- Simultaneous push and pop:
  - Count is unchanged. This is legal when full, because the pop frees a slot in the same cycle.
  - Queue_Full is computed before the pop, so the decoder sees full and will not push.
- Pointers wrap modulo DEPTH.
- beat_cnt is LEN_W wide; len = 255 gives a 256-beat burst with no overflow.

Test Plan:
- Single burst: AW_Push with Q_Enables=2'b10, AW_Len=3, then 4 W beats with wlast on beat 4 -> only slave_wvalid[1] toggles; slave_wlast[1] high on beat 4 only; queue empty after; Wlast_Err=0.
- Ordering: push slave0 len0, slave1 len1, slave0 len2 back-to-back -> beats route 1 to s0, 2 to s1, 3 to s0 in order; slave_wready[1] held low 3 cycles stalls Master_AXI_wready and no beat is lost.
- Full and overflow, DEPTH=4: 4 pushes -> Queue_Full=1; 5th push -> dropped, Ovf_Err=1; last beat of head burst plus push in the same cycle -> count stays 4.
- Sink and error: Q_Enables=0, len 1 -> 2 beats accepted with wready=1 and no slave_wvalid; master wlast on beat 1 -> Wlast_Err=1.
- Max burst: len=255 -> 256 beats; slave_wlast only on beat 256; beat_cnt returns to 0.
- Reset mid-burst: reset_n low after beat 2 of a 4-beat burst -> all outputs return to reset values immediately; after release, a new push routes correctly from beat 1.
